// File: rtl/led_seg7_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : led_seg7_overlay
//  Purpose  : Video overlay pixel generator. It draws NUM_LED_ROWS rows of
//             LED indicators and a NUM_DIGITS-digit 7-segment display with
//             decimal points. Display data is latched once per frame, at the
//             vsync rising edge. The result is emitted as sync-aligned 10-bit
//             RGB words after a fixed 2-cycle pipeline.
//  Ports    : clk_video, reset (async, active-high)
//             hsync/vsync/active, pixel_count/line_count    - from hvsync
//             leds/led_blink, segments/dp/digit_blank        - display data
//             o_hsync/o_vsync/o_active                       - delayed syncs
//             red_word/green_word/blue_word                  - pixel data
//  Macro    : OVERLAY_BLINK_EN - builds the per-frame blink counter so that
//             LEDs with a blink bit set are forced off in alternate
//             2^BLINK_LOG2-frame phases.
//  Revision : 1.0 - initial release
// ============================================================================
module led_seg7_overlay #(
   parameter int NUM_LED_ROWS = 2,
   parameter int LEDS_PER_ROW = 16,
   parameter int NUM_DIGITS   = 6,
   parameter int X_ORG        = 0,
   parameter int Y_LED        = 64,
   parameter int Y_SEG        = 150,
   parameter int BLINK_LOG2   = 4
) (
   input  logic                                 clk_video,
   input  logic                                 reset,
   input  logic                                 hsync,
   input  logic                                 vsync,
   input  logic                                 active,
   input  logic [11:0]                          pixel_count,
   input  logic [11:0]                          line_count,
   input  logic [NUM_LED_ROWS*LEDS_PER_ROW-1:0] leds,
   input  logic [NUM_LED_ROWS*LEDS_PER_ROW-1:0] led_blink,
   input  logic [NUM_DIGITS*4-1:0]              segments,
   input  logic [NUM_DIGITS-1:0]                dp,
   input  logic [NUM_DIGITS-1:0]                digit_blank,
   output logic                                 o_hsync,
   output logic                                 o_vsync,
   output logic                                 o_active,
   output logic [9:0]                           red_word,
   output logic [9:0]                           green_word,
   output logic [9:0]                           blue_word
);

   localparam int          NLED   = NUM_LED_ROWS * LEDS_PER_ROW;
   localparam logic [31:0] XORG_U = X_ORG;
   localparam logic [31:0] YLED_U = Y_LED;
   localparam logic [31:0] YSEG_U = Y_SEG;

   // ------------------------------------------------------------------------
   // Frame edge detection and data latch
   // ------------------------------------------------------------------------
   logic            vs_d_q;
   logic            armed_q;     // set once vsync has been seen low after reset
   logic            frame_edge;
   logic [NLED-1:0] leds_q;
   logic [NUM_DIGITS*4-1:0] seg_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [NUM_DIGITS-1:0]   blank_q;

   // A vsync already high when reset is released is not an edge: armed_q
   // only becomes 1 after vsync has been observed low.
   assign frame_edge = vsync & ~vs_d_q & armed_q;

   always_ff @(posedge clk_video or posedge reset) begin
      if (reset) begin
         vs_d_q  <= 1'b0;
         armed_q <= 1'b0;
         leds_q  <= '0;
         seg_q   <= '0;
         dp_q    <= '0;
         blank_q <= '0;
      end else begin
         vs_d_q <= vsync;
         if (!vsync) armed_q <= 1'b1;
         if (frame_edge) begin
            leds_q  <= leds;
            seg_q   <= segments;
            dp_q    <= dp;
            blank_q <= digit_blank;
         end
      end
   end

   // During the edge cycle itself the register still holds the old frame, so
   // the incoming data is forwarded. The pixel whose counters arrive with the
   // edge is then the first one drawn from the new data.
   logic [NLED-1:0]         leds_eff;
   logic [NUM_DIGITS*4-1:0] seg_eff;
   logic [NUM_DIGITS-1:0]   dp_eff;
   logic [NUM_DIGITS-1:0]   blank_eff;
   logic [NLED-1:0]         led_show;

   assign leds_eff  = frame_edge ? leds        : leds_q;
   assign seg_eff   = frame_edge ? segments    : seg_q;
   assign dp_eff    = frame_edge ? dp          : dp_q;
   assign blank_eff = frame_edge ? digit_blank : blank_q;

`ifdef OVERLAY_BLINK_EN
   logic [NLED-1:0]       blink_q;
   logic [BLINK_LOG2:0]   blink_cnt_q;
   logic [BLINK_LOG2:0]   blink_cnt_d;
   logic                  blink_phase;
   logic [NLED-1:0]       blink_eff;

   assign blink_cnt_d = blink_cnt_q + {{BLINK_LOG2{1'b0}}, 1'b1};
   assign blink_phase = frame_edge ? blink_cnt_d[BLINK_LOG2] : blink_cnt_q[BLINK_LOG2];
   assign blink_eff   = frame_edge ? led_blink : blink_q;
   assign led_show    = leds_eff & ~(blink_eff & {NLED{blink_phase}});

   always_ff @(posedge clk_video or posedge reset) begin
      if (reset) begin
         blink_q     <= '0;
         blink_cnt_q <= '0;
      end else if (frame_edge) begin
         blink_q     <= led_blink;
         blink_cnt_q <= blink_cnt_d;
      end
   end
`else
   logic [NLED-1:0] unused_blink;
   assign unused_blink = led_blink;
   assign led_show     = leds_eff;
`endif

   // ------------------------------------------------------------------------
   // Pixel classification
   // ------------------------------------------------------------------------
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // Returns {hit, colour index} for one digit cell. Segments are tested
   // before the decimal point; the regions are disjoint for one cell anyway.
   function automatic logic [3:0] digit_px(input logic [31:0] xr, input logic [31:0] ln,
                                           input logic [31:0] bx, input logic [3:0] nib,
                                           input logic dp_b, input logic blank_b);
      logic [6:0] s;
      logic mid, lft, rgt, h_a, h_g, h_d, v_u, v_l, in_dp, hit, on;
      s     = hex7(nib);
      mid   = (xr > bx + 32'd32) && (xr < bx + 32'd56);
      lft   = (xr > bx + 32'd24) && (xr < bx + 32'd32);
      rgt   = (xr > bx + 32'd56) && (xr < bx + 32'd64);
      h_a   = (ln > YSEG_U)          && (ln < YSEG_U + 32'd8);
      h_g   = (ln > YSEG_U + 32'd30) && (ln < YSEG_U + 32'd38);
      h_d   = (ln > YSEG_U + 32'd62) && (ln < YSEG_U + 32'd70);
      v_u   = (ln > YSEG_U + 32'd8)  && (ln < YSEG_U + 32'd30);
      v_l   = (ln > YSEG_U + 32'd38) && (ln < YSEG_U + 32'd62);
      in_dp = (xr > bx + 32'd58) && (xr < bx + 32'd64) && h_d;
      hit   = 1'b1;
      on    = 1'b0;
      if      (mid && h_a) on = s[0];
      else if (rgt && v_u) on = s[1];
      else if (rgt && v_l) on = s[2];
      else if (mid && h_d) on = s[3];
      else if (lft && v_l) on = s[4];
      else if (lft && v_u) on = s[5];
      else if (mid && h_g) on = s[6];
      else if (in_dp)      on = dp_b;
      else                 hit = 1'b0;
      return {hit, blank_b ? 3'd0 : (on ? 3'd5 : 3'd6)};
   endfunction

   logic [31:0]     px_abs, ln_abs, xr, led_sh;
   logic            in_x, seg_hit, led_hit;
   logic [2:0]      seg_col, led_col, col;
   logic [3:0]      dres;
   logic [NLED-1:0] led_vec;

   assign px_abs = {20'd0, pixel_count};
   assign ln_abs = {20'd0, line_count};
   assign xr     = px_abs - XORG_U;
   assign in_x   = px_abs >= XORG_U;

   always_comb begin
      seg_hit = 1'b0;
      seg_col = 3'd0;
      led_hit = 1'b0;
      led_col = 3'd0;
      dres    = 4'd0;
      led_sh  = 32'd0;
      led_vec = '0;
      col     = 3'd0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         dres = digit_px(xr, ln_abs, 32'(64 * (NUM_DIGITS - 1 - d)), seg_eff[4*d +: 4],
                         dp_eff[d], blank_eff[d]);
         if (!seg_hit && dres[3]) begin
            seg_hit = 1'b1;
            seg_col = dres[2:0];
         end
      end
      for (int r = 0; r < NUM_LED_ROWS; r++) begin
         if ((ln_abs > YLED_U + 32'(32 * r)) && (ln_abs < YLED_U + 32'(32 * r + 16)) &&
             (xr < 32'(32 * LEDS_PER_ROW)) && xr[4]) begin
            // LED index counts from the right: x[9:5] = 0 is the leftmost LED.
            led_sh  = 32'(r * LEDS_PER_ROW + LEDS_PER_ROW - 1) - {27'd0, xr[9:5]};
            led_vec = led_show >> led_sh;
            led_hit = 1'b1;
            if (r % 2 == 0) led_col = led_vec[0] ? 3'd1 : 3'd2;
            else            led_col = led_vec[0] ? 3'd3 : 3'd4;
         end
      end
      if (in_x) col = led_hit ? led_col : seg_col;
   end

   // ------------------------------------------------------------------------
   // Two-stage output pipeline
   // ------------------------------------------------------------------------
   function automatic logic [29:0] palette(input logic [2:0] idx);
      case (idx)
         3'd1:    palette = {10'h01F, 10'h3FF, 10'h01F};
         3'd2:    palette = {10'h01F, 10'h03F, 10'h01F};
         3'd3:    palette = {10'h3FF, 10'h01F, 10'h01F};
         3'd4:    palette = {10'h03F, 10'h01F, 10'h01F};
         3'd5:    palette = {10'h3FF, 10'h3FF, 10'h01F};
         3'd6:    palette = {10'h03F, 10'h03F, 10'h01F};
         default: palette = {10'h01F, 10'h01F, 10'h03F};
      endcase
   endfunction

   logic [2:0] idx_q;
   logic       hs_q, vs_q, act_q;

   always_ff @(posedge clk_video or posedge reset) begin
      if (reset) begin
         idx_q      <= 3'd0;
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         act_q      <= 1'b0;
         o_hsync    <= 1'b0;
         o_vsync    <= 1'b0;
         o_active   <= 1'b0;
         red_word   <= 10'd0;
         green_word <= 10'd0;
         blue_word  <= 10'd0;
      end else begin
         idx_q    <= col;
         hs_q     <= hsync;
         vs_q     <= vsync;
         act_q    <= active;
         o_hsync  <= hs_q;
         o_vsync  <= vs_q;
         o_active <= act_q;
         {red_word, green_word, blue_word} <= palette(idx_q);
      end
   end

endmodule
`default_nettype wire

// File: doc/led_seg7_overlay.md
# led_seg7_overlay

Parametrised pixel generator that draws multi-row LED indicator banks and an N-digit 7-segment display with decimal points as a video overlay. It sits between `hvsync` and the `hdmi` encoder in the `clk_video` domain. It consumes sync and counter signals, latches all display data once per frame, and emits sync-aligned 10-bit RGB words. It supersedes the fixed 16+16 LED / 6-digit display path and adds LED row count, digit count, placement, blanking, decimal points and blink as parameters or inputs.

## Interface
- `NUM_LED_ROWS`, 2: number of LED rows (1..4); row 0 is topmost.
- `LEDS_PER_ROW`, 16: LEDs per row (1..32).
- `NUM_DIGITS`, 6: 7-segment digits (1..8); digit 0 is rightmost.
- `X_ORG`, 0: left pixel of the overlay.
- `Y_LED`, 64: first line of LED row 0.
- `Y_SEG`, 150: first line of the digit band.
- `BLINK_LOG2`, 4: blink half-period is 2^BLINK_LOG2 frames.
- `clk_video  in  1`: pixel clock.
- `reset  in  1`: asynchronous, active-high.
- `hsync, vsync, active  in  1 each`: from `hvsync`.
- `pixel_count, line_count  in  12 each`: from `hvsync`.
- `leds  in  NUM_LED_ROWS*LEDS_PER_ROW`: row r occupies bits [r*LEDS_PER_ROW +: LEDS_PER_ROW].
- `led_blink  in  NUM_LED_ROWS*LEDS_PER_ROW`: per-LED blink enable.
- `segments  in  NUM_DIGITS*4`: hex nibble per digit; digit d occupies bits [4d+3:4d].
- `dp  in  NUM_DIGITS`: decimal point per digit.
- `digit_blank  in  NUM_DIGITS`: 1 draws the digit as background.
- `o_hsync, o_vsync, o_active  out  1 each`: syncs delayed to match the pixel data.
- `red_word, green_word, blue_word  out  10 each`: pixel data for `hdmi`.

## Operation
- **Frame latch:** `vsync` is registered as `vs_d`. The cycle in which `vsync=1` and `vs_d=0` is the frame edge. On that edge, `leds`, `led_blink`, `segments`, `dp` and `digit_blank` are captured. Inputs are ignored at all other times.
- **Coordinates:** x = `pixel_count` − `X_ORG`. When `pixel_count` < `X_ORG`, the pixel is background.
- **LED row r:**
  - Lit when `line_count` > Y_LED+32r and `line_count` < Y_LED+32r+16.
  - Within that band, x < 32·LEDS_PER_ROW, x[4]=1, and the LED index is LEDS_PER_ROW−1−x[9:5].
  - Colour: green on/off (1/2) for even rows, red on/off (3/4) for odd rows.
- **Digit d:**
  - Cell base bx = 64·(NUM_DIGITS−1−d); cell lines start at Y_SEG.
  - Horizontal segments a, g, d: x in (bx+32, bx+56); lines (Y_SEG, Y_SEG+8), (Y_SEG+30, Y_SEG+38), (Y_SEG+62, Y_SEG+70).
  - Left verticals f/e: x in (bx+24, bx+32).
  - Right verticals b/c: x in (bx+56, bx+64).
  - Vertical line ranges: (Y_SEG+8, Y_SEG+30) upper; (Y_SEG+38, Y_SEG+62) lower.
  - DP: x in (bx+58, bx+64), lines (Y_SEG+62, Y_SEG+70).
  - Segment on → colour 5; off → 6; `digit_blank` → 0.
  - Hex decode table: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (bit0=a … bit6=g).
- **Palette:** Reset gives 0 on all words.

  | Index | Meaning | R | G | B |
  |---|---|---|---|---|
  | 0 | gray | 01F | 01F | 03F |
  | 1 | green | 01F | 3FF | 01F |
  | 2 | dk green | 01F | 03F | 01F |
  | 3 | red | 3FF | 01F | 01F |
  | 4 | dk red | 03F | 01F | 01F |
  | 5 | yellow | 3FF | 3FF | 01F |
  | 6 | dk yellow | 03F | 03F | 01F |
  | 7 | gray | 01F | 01F | 03F |

- **Overlaps:** Overlapping regions from parameter choices resolve with priority LED rows > segments > DP > background.

## Timing
- **Stage 1** registers the colour index, and the syncs/active.
- **Stage 2** registers the RGB words, `o_hsync`, `o_vsync` and `o_active`.
- Latency is exactly 2 `clk_video` cycles from counter input to RGB output. Syncs are delayed identically.
- Data captured at a frame edge first affects the pixel presented 2 cycles after that edge. A mid-frame input change therefore never tears.
- **Reset:**
  - Asynchronous reset clears all outputs, `vs_d`, the latched data and the frame counter to 0 immediately.
  - The first frame edge after release latches fresh data.
  - A `vsync` held high through reset release does not count as an edge.

## Configuration
- **`OVERLAY_BLINK_EN` defined:**
  - A (BLINK_LOG2+1)-bit frame counter increments at each frame edge and wraps.
  - While its MSB=1, any LED with its latched blink bit set renders as off (2 or 4).
- **Not defined:** The counter is not built, `led_blink` is ignored, and LEDs render steady.

## Test plan
- Defaults, leds=32'h0001_8000 latched at frame edge → row 0 LED 15 (leftmost) and row 1 LED 0 (rightmost) output G=3FF / R=3FF respectively; all other LEDs output dark colour; outputs 2 cycles after counters.
- segments=24'h0123AF, change inputs mid-frame → displayed digits change only after next vsync rising edge; digit 0 "F" lights a,e,f,g (colour 5).
- dp=6'b000001, digit_blank=6'b000010 → DP of digit 0 yellow; all pixels of digit 1 gray (01F,01F,03F).
- With OVERLAY_BLINK_EN, BLINK_LOG2=1, blink on LED 3 lit → on for 2 frames, off for 2, repeating past counter wrap; without the macro, steady on.
- Assert reset mid-line → all outputs 0 same cycle; after release, first active pixel gray, latched data zero until next frame edge.
- NUM_LED_ROWS=4, NUM_DIGITS=8, X_ORG=100 → pixel_count<100 gray; row 3 uses red palette; digit 7 cell starts at x=0.
